// File: rtl/button_bank_debouncer.sv
// Bank of independent push-button conditioners: synchroniser, debouncer, press lockout,
// long-press detection. Define BUTTON_AUTOREPEAT_EN to add auto-repeat press pulses after a long press.
module button_bank_debouncer #(
    parameter int NUM_BUTTONS    = 4,
    parameter int DEBOUNCE_BITS  = 11,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int HOLD_CYCLES    = 50000,
    parameter int REPEAT_CYCLES  = 10000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttons_in,
    output logic [NUM_BUTTONS-1:0] state_out,
    output logic [NUM_BUTTONS-1:0] press_out,
    output logic [NUM_BUTTONS-1:0] release_out,
    output logic [NUM_BUTTONS-1:0] hold_out
);

    localparam int LOCK_W = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(HOLD_CYCLES - 1);

    if (NUM_BUTTONS < 1 || NUM_BUTTONS > 32 || DEBOUNCE_BITS < 1 ||
        LOCKOUT_CYCLES < 0 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("button_bank_debouncer: illegal parameter combination");
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES + 1) : 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
`endif

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
        logic                     sync1_q;
        logic                     sync2_q;
        logic [DEBOUNCE_BITS-1:0] stab_q;
        logic [DEBOUNCE_BITS-1:0] stab_d;
        logic                     state_q;
        logic                     state_d;
        logic [LOCK_W-1:0]        lock_q;
        logic [LOCK_W-1:0]        lock_d;
        logic [HOLD_W-1:0]        hold_q;
        logic [HOLD_W-1:0]        hold_d;
        logic                     press_q;
        logic                     press_d;
        logic                     release_q;
        logic                     release_d;
        logic                     hold_pulse_q;
        logic                     hold_pulse_d;
        logic                     rise;
        logic                     fall;
`ifdef BUTTON_AUTOREPEAT_EN
        logic [RPT_W-1:0]         rpt_q;
        logic [RPT_W-1:0]         rpt_d;
        logic                     rpt_fire;
`endif

        always_comb begin
            // Counter restarts on any sample that agrees with the current debounced level.
            stab_d  = '0;
            state_d = state_q;
            if (sync2_q != state_q) begin
                if (&stab_q) begin
                    state_d = ~state_q;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end

            rise = state_d & ~state_q;
            fall = ~state_d & state_q;

            lock_d = lock_q;
            if (lock_q != '0) begin
                lock_d = lock_q - 1'b1;
            end

            press_d = 1'b0;
            if (rise && (lock_q == '0)) begin
                press_d = 1'b1;
                lock_d  = LOCK_LOAD;
            end

            release_d = fall;

            hold_d       = '0;
            hold_pulse_d = 1'b0;
            if (state_q) begin
                hold_d       = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
                hold_pulse_d = (hold_q == HOLD_PRE) && state_d;
            end

`ifdef BUTTON_AUTOREPEAT_EN
            // Repeats run only once the hold counter has saturated and never touch lockout.
            rpt_d    = '0;
            rpt_fire = 1'b0;
            if (state_q && state_d && (hold_q == HOLD_MAX)) begin
                if (rpt_q == RPT_LAST) begin
                    rpt_fire = 1'b1;
                end else begin
                    rpt_d = rpt_q + 1'b1;
                end
            end
            if (rpt_fire) begin
                press_d = 1'b1;
            end
`endif
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync1_q      <= 1'b0;
                sync2_q      <= 1'b0;
                stab_q       <= '0;
                state_q      <= 1'b0;
                lock_q       <= '0;
                hold_q       <= '0;
                press_q      <= 1'b0;
                release_q    <= 1'b0;
                hold_pulse_q <= 1'b0;
            end else begin
                sync1_q      <= ~buttons_in[g];
                sync2_q      <= sync1_q;
                stab_q       <= stab_d;
                state_q      <= state_d;
                lock_q       <= lock_d;
                hold_q       <= hold_d;
                press_q      <= press_d;
                release_q    <= release_d;
                hold_pulse_q <= hold_pulse_d;
            end
        end

`ifdef BUTTON_AUTOREPEAT_EN
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rpt_q <= '0;
            end else begin
                rpt_q <= rpt_d;
            end
        end
`endif

        assign state_out[g]   = state_q;
        assign press_out[g]   = press_q;
        assign release_out[g] = release_q;
        assign hold_out[g]    = hold_pulse_q;
    end

endmodule
